multi_chan_accum: RTL and testbench

Parametrised multi-channel accumulator; successor to the single-channel A+B registered adder. Each accepted sample adds A+B into the accumulator of the selected channel and emits the updated total through a one-entry valid/ready output register. A flush sequencer drains and clears all channels in order. It sits between the sample source and the downstream statistics logic.

---
 rtl/multi_chan_accum_pkg.sv | 35 +++
 rtl/multi_chan_accum_sat_add.sv | 47 ++++
 rtl/multi_chan_accum.sv | 183 ++++++++++++++++++
 tb/tb_multi_chan_accum.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_chan_accum_pkg.sv
// ---------------------------------------------------------------------------
// multi_chan_accum_pkg
// Shared types and helpers for the multi-channel accumulator.
//   - ch_width()  : channel index width for a given channel count (min 1)
//   - state_t     : sequencer state (ST_RUN accepts samples, ST_FLUSH drains)
//   - out_rec_t   : output record (ch, sum, cnt, ovf, flush) sized for the
//                   default configuration (32-bit data, 4 channels, 16-bit
//                   counters)
// Optional feature macro used by the design: MULTI_CHAN_ACCUM_SAT_EN
// ---------------------------------------------------------------------------
package multi_chan_accum_pkg;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    localparam int MCA_DATA_W = 32;
    localparam int MCA_NUM_CH = 4;
    localparam int MCA_CNT_W  = 16;
    localparam int MCA_CH_W   = ch_width(MCA_NUM_CH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [MCA_CH_W-1:0]   ch;
        logic [MCA_DATA_W-1:0] sum;
        logic [MCA_CNT_W-1:0]  cnt;
        logic                  ovf;
        logic                  flush;
    } out_rec_t;

endpackage

// File: rtl/multi_chan_accum_sat_add.sv
// ---------------------------------------------------------------------------
// accum_sat_add
// Combinational three-input adder: base + a + b.
// Default build wraps modulo 2^DATA_W and flags the carry on ovf.
// With MULTI_CHAN_ACCUM_SAT_EN defined the result clamps to all-ones on a
// carry or when the channel's sticky overflow bit is already set.
// Ports:
//   base, a, b : operands (DATA_W)
//   sticky     : channel already saturated (SAT build only)
//   sum        : result (DATA_W)
//   ovf        : overflow flag for this update
// ---------------------------------------------------------------------------
module accum_sat_add #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
`ifdef MULTI_CHAN_ACCUM_SAT_EN
    input  logic              sticky,
`endif
    output logic [DATA_W-1:0] sum,
    output logic              ovf
);

    // Two guard bits: three full-scale operands can carry into bit DATA_W+1.
    logic [DATA_W+1:0] full;
    logic              carry;

    always_comb begin
        full  = {2'b00, base} + {2'b00, a} + {2'b00, b};
        carry = |full[DATA_W+1:DATA_W];
    end

`ifdef MULTI_CHAN_ACCUM_SAT_EN
    always_comb begin
        ovf = carry | sticky;
        sum = ovf ? {DATA_W{1'b1}} : full[DATA_W-1:0];
    end
`else
    always_comb begin
        ovf = carry;
        sum = full[DATA_W-1:0];
    end
`endif

endmodule

// File: rtl/multi_chan_accum.sv
// ---------------------------------------------------------------------------
// multi_chan_accum
// Multi-channel accumulator. Each accepted sample adds IN_A+IN_B into the
// selected channel (or restarts it with IN_CLR) and emits the updated total
// through a one-entry valid/ready output register. FLUSH_REQ starts a drain
// that emits every channel in order and clears it.
// Optional feature: MULTI_CHAN_ACCUM_SAT_EN (saturating accumulators with a
// sticky per-channel overflow bit); default build wraps.
// Ports:
//   CLK, RST_X            : clock, asynchronous active-low reset
//   IN_VALID/IN_READY     : sample handshake
//   IN_CH, IN_A, IN_B     : target channel and operands
//   IN_CLR                : restart channel with A+B, count 1
//   FLUSH_REQ             : request drain of all channels
//   OUT_VALID/OUT_READY   : output handshake
//   OUT_CH, OUT_SUM,
//   OUT_CNT, OUT_OVF,
//   OUT_FLUSH             : output record
//   BUSY                  : flush in progress
// ---------------------------------------------------------------------------
module multi_chan_accum
    import multi_chan_accum_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16,
    localparam int CH_W  = ch_width(NUM_CH)
) (
    input  logic              CLK,
    input  logic              RST_X,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CH_W-1:0]   IN_CH,
    input  logic [DATA_W-1:0] IN_A,
    input  logic [DATA_W-1:0] IN_B,
    input  logic              IN_CLR,
    input  logic              FLUSH_REQ,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CH_W-1:0]   OUT_CH,
    output logic [DATA_W-1:0] OUT_SUM,
    output logic [CNT_W-1:0]  OUT_CNT,
    output logic              OUT_OVF,
    output logic              OUT_FLUSH,
    output logic              BUSY
);

    // Output record at this instance's widths (the package record is fixed
    // to the default configuration).
    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] sum;
        logic [CNT_W-1:0]  cnt;
        logic              ovf;
        logic              flush;
    } out_slot_t;

    logic [DATA_W-1:0] acc [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];
`ifdef MULTI_CHAN_ACCUM_SAT_EN
    logic [NUM_CH-1:0] sticky;
    logic              add_sticky;
`endif

    state_t            state;
    logic [CH_W-1:0]   idx;
    out_slot_t         slot;
    logic              slot_valid;

    logic              slot_free;
    logic              accept;
    logic [DATA_W-1:0] add_base;
    logic [DATA_W-1:0] add_sum;
    logic              add_ovf;

    // The slot can take a new record when empty or being drained this cycle.
    always_comb begin
        slot_free = !slot_valid || OUT_READY;
        IN_READY  = (state == ST_RUN) && slot_free && !FLUSH_REQ;
        accept    = IN_VALID && IN_READY;
        add_base  = IN_CLR ? '0 : acc[IN_CH];
    end

`ifdef MULTI_CHAN_ACCUM_SAT_EN
    // A restart discards the channel's saturated history.
    assign add_sticky = sticky[IN_CH] & ~IN_CLR;
`endif

    accum_sat_add #(
        .DATA_W (DATA_W)
    ) u_add (
        .base   (add_base),
        .a      (IN_A),
        .b      (IN_B),
`ifdef MULTI_CHAN_ACCUM_SAT_EN
        .sticky (add_sticky),
`endif
        .sum    (add_sum),
        .ovf    (add_ovf)
    );

    // Sequencer, channel state and output slot. Sample writes and flush
    // reads are mutually exclusive by state, so there is no port conflict on
    // the channel arrays. Back-to-back samples to one channel read the value
    // written on the previous edge directly from acc/cnt.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state      <= ST_RUN;
            idx        <= '0;
            slot_valid <= 1'b0;
            slot       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
`ifdef MULTI_CHAN_ACCUM_SAT_EN
            sticky     <= '0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (accept) begin
                        acc[IN_CH]  <= add_sum;
                        cnt[IN_CH]  <= IN_CLR ? CNT_W'(1) : cnt[IN_CH] + 1'b1;
`ifdef MULTI_CHAN_ACCUM_SAT_EN
                        sticky[IN_CH] <= add_ovf;
`endif
                        slot.ch     <= IN_CH;
                        slot.sum    <= add_sum;
                        slot.cnt    <= IN_CLR ? CNT_W'(1) : cnt[IN_CH] + 1'b1;
                        slot.ovf    <= add_ovf;
                        slot.flush  <= 1'b0;
                        slot_valid  <= 1'b1;
                    end else begin
                        if (slot_free) begin
                            slot_valid <= 1'b0;
                        end
                        if (FLUSH_REQ) begin
                            state <= ST_FLUSH;
                            idx   <= '0;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (slot_free) begin
                        slot.ch    <= idx;
                        slot.sum   <= acc[idx];
                        slot.cnt   <= cnt[idx];
                        slot.ovf   <= 1'b0;
                        slot.flush <= 1'b1;
                        slot_valid <= 1'b1;
                        acc[idx]   <= '0;
                        cnt[idx]   <= '0;
`ifdef MULTI_CHAN_ACCUM_SAT_EN
                        sticky[idx] <= 1'b0;
`endif
                        if (idx == CH_W'(NUM_CH - 1)) begin
                            state <= ST_RUN;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_RUN;
                    idx   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        OUT_VALID = slot_valid;
        OUT_CH    = slot.ch;
        OUT_SUM   = slot.sum;
        OUT_CNT   = slot.cnt;
        OUT_OVF   = slot.ovf;
        OUT_FLUSH = slot.flush;
        BUSY      = (state == ST_FLUSH);
    end

endmodule

// File: tb/tb_multi_chan_accum.sv
// ---------------------------------------------------------------------------
// tb_multi_chan_accum
// Self-checking bench for multi_chan_accum (default parameters). A reference
// model tracks channel totals, counts, the output slot and flush progress
// with plain arithmetic; a negedge process compares the DUT against it every
// cycle. Directed sequences pin known literal results, then randomized
// traffic runs against the model. Honours MULTI_CHAN_ACCUM_SAT_EN.
// ---------------------------------------------------------------------------
module tb_multi_chan_accum;
    import multi_chan_accum_pkg::*;

    localparam int NUM_CH = MCA_NUM_CH;

    logic                  CLK;
    logic                  RST_X;
    logic                  IN_VALID;
    logic                  IN_READY;
    logic [MCA_CH_W-1:0]   IN_CH;
    logic [MCA_DATA_W-1:0] IN_A;
    logic [MCA_DATA_W-1:0] IN_B;
    logic                  IN_CLR;
    logic                  FLUSH_REQ;
    logic                  OUT_VALID;
    logic                  OUT_READY;
    logic [MCA_CH_W-1:0]   OUT_CH;
    logic [MCA_DATA_W-1:0] OUT_SUM;
    logic [MCA_CNT_W-1:0]  OUT_CNT;
    logic                  OUT_OVF;
    logic                  OUT_FLUSH;
    logic                  BUSY;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    multi_chan_accum #(
        .DATA_W (MCA_DATA_W),
        .NUM_CH (MCA_NUM_CH),
        .CNT_W  (MCA_CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST_X     (RST_X),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_CH     (IN_CH),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .IN_CLR    (IN_CLR),
        .FLUSH_REQ (FLUSH_REQ),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_CH    (OUT_CH),
        .OUT_SUM   (OUT_SUM),
        .OUT_CNT   (OUT_CNT),
        .OUT_OVF   (OUT_OVF),
        .OUT_FLUSH (OUT_FLUSH),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input int ch, input logic [31:0] a,
                                 input logic [31:0] b, input logic clr,
                                 input logic flush, input logic ordy);
        @(posedge CLK);
        #1;
        IN_VALID  = v;
        IN_CH     = MCA_CH_W'(ch);
        IN_A      = a;
        IN_B      = b;
        IN_CLR    = clr;
        FLUSH_REQ = flush;
        OUT_READY = ordy;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_acc     [NUM_CH];
    logic [15:0] m_cnt     [NUM_CH];
    bit          m_sticky  [NUM_CH];
    bit          m_flushing;
    int          m_next;
    bit          exp_valid;
    out_rec_t    exp_rec;

    always @(posedge CLK or negedge RST_X) begin : ref_model
        bit              free;
        int              c;
        longint unsigned full;
        logic [31:0]     base;
        logic [31:0]     new_sum;
        logic [15:0]     new_cnt;
        bit              new_ovf;
        if (!RST_X) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_acc[i]    <= '0;
                m_cnt[i]    <= '0;
                m_sticky[i] <= 1'b0;
            end
            m_flushing <= 1'b0;
            m_next     <= 0;
            exp_valid  <= 1'b0;
            exp_rec    <= '0;
        end else begin
            free = !exp_valid || OUT_READY;
            if (m_flushing) begin
                if (free) begin
                    exp_rec   <= '{ch: MCA_CH_W'(m_next), sum: m_acc[m_next],
                                   cnt: m_cnt[m_next], ovf: 1'b0, flush: 1'b1};
                    exp_valid <= 1'b1;
                    m_acc[m_next]    <= '0;
                    m_cnt[m_next]    <= '0;
                    m_sticky[m_next] <= 1'b0;
                    if (m_next == NUM_CH - 1) begin
                        m_flushing <= 1'b0;
                        m_next     <= 0;
                    end else begin
                        m_next <= m_next + 1;
                    end
                end
            end else if (IN_VALID && free && !FLUSH_REQ) begin
                c       = int'(IN_CH);
                base    = IN_CLR ? 32'd0 : m_acc[c];
                full    = longint'(base) + longint'(IN_A) + longint'(IN_B);
                new_ovf = (full > 64'h0000_0000_FFFF_FFFF);
`ifdef MULTI_CHAN_ACCUM_SAT_EN
                new_ovf = new_ovf || (!IN_CLR && m_sticky[c]);
                new_sum = new_ovf ? 32'hFFFF_FFFF : 32'(full);
                m_sticky[c] <= new_ovf;
`else
                new_sum = 32'(full % 64'h1_0000_0000);
`endif
                new_cnt   = IN_CLR ? 16'd1 : 16'((int'(m_cnt[c]) + 1) % 65536);
                m_acc[c]  <= new_sum;
                m_cnt[c]  <= new_cnt;
                exp_rec   <= '{ch: IN_CH, sum: new_sum, cnt: new_cnt, ovf: new_ovf, flush: 1'b0};
                exp_valid <= 1'b1;
            end else begin
                if (free) exp_valid <= 1'b0;
                if (FLUSH_REQ) begin
                    m_flushing <= 1'b1;
                    m_next     <= 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        if (cmp_en) begin
            if (!RST_X) begin
                checkOutput("rst_out_valid", OUT_VALID, 0);
                checkOutput("rst_busy", BUSY, 0);
            end else begin
                checkOutput("cmp_in_ready", IN_READY,
                            !m_flushing && (!exp_valid || OUT_READY) && !FLUSH_REQ);
                checkOutput("cmp_busy", BUSY, m_flushing);
                checkOutput("cmp_out_valid", OUT_VALID, exp_valid);
                if (exp_valid) begin
                    checkOutput("cmp_out_ch", OUT_CH, exp_rec.ch);
                    checkOutput("cmp_out_sum", OUT_SUM, exp_rec.sum);
                    checkOutput("cmp_out_cnt", OUT_CNT, exp_rec.cnt);
                    checkOutput("cmp_out_ovf", OUT_OVF, exp_rec.ovf);
                    checkOutput("cmp_out_flush", OUT_FLUSH, exp_rec.flush);
                end
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        RST_X = 1'b0; IN_VALID = 1'b0; IN_CH = '0; IN_A = '0; IN_B = '0;
        IN_CLR = 1'b0; FLUSH_REQ = 1'b0; OUT_READY = 1'b1;
        #1 cmp_en = 1'b1;

        repeat (2) @(negedge CLK);
        checkOutput("reset_out_valid", OUT_VALID, 0);
        checkOutput("reset_in_ready", IN_READY, 1);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_out_sum", OUT_SUM, 0);
        checkOutput("reset_out_cnt", OUT_CNT, 0);
        #2 RST_X = 1'b1;

        // ch0: 3+4 then 1+1
        applyStimulus(1, 0, 3, 4, 0, 0, 1);
        applyStimulus(1, 0, 1, 1, 0, 0, 1);
        @(negedge CLK);
        checkOutput("t1_valid", OUT_VALID, 1);
        checkOutput("t1_sum7", OUT_SUM, 7);
        checkOutput("t1_cnt1", OUT_CNT, 1);
        checkOutput("t1_ch0", OUT_CH, 0);
        checkOutput("t1_model_sum7", exp_rec.sum, 7);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        checkOutput("t1_sum9", OUT_SUM, 9);
        checkOutput("t1_cnt2", OUT_CNT, 2);
        checkOutput("t1_model_sum9", exp_rec.sum, 9);

        // ch1 overflow
        applyStimulus(1, 1, 32'hFFFF_FFFF, 2, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
`ifdef MULTI_CHAN_ACCUM_SAT_EN
        checkOutput("t2_sum_sat", OUT_SUM, 64'hFFFF_FFFF);
`else
        checkOutput("t2_sum_wrap", OUT_SUM, 1);
`endif
        checkOutput("t2_ovf", OUT_OVF, 1);
        checkOutput("t2_ch1", OUT_CH, 1);

        // backpressure on ch3
        applyStimulus(1, 3, 5, 0, 0, 0, 0);
        applyStimulus(1, 3, 6, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checkOutput("t3_stall_in_ready", IN_READY, 0);
            checkOutput("t3_stall_sum", OUT_SUM, 5);
            checkOutput("t3_stall_valid", OUT_VALID, 1);
        end
        applyStimulus(1, 3, 6, 0, 0, 0, 1);
        #1 checkOutput("t3_release_in_ready", IN_READY, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        checkOutput("t3_sum11", OUT_SUM, 11);
        checkOutput("t3_cnt2", OUT_CNT, 2);

        // ch2 accumulate 10 then restart with 5
        applyStimulus(1, 2, 4, 6, 0, 0, 1);
        applyStimulus(1, 2, 5, 0, 1, 0, 1);
        @(negedge CLK);
        checkOutput("t4_sum10", OUT_SUM, 10);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        checkOutput("t4_clr_sum5", OUT_SUM, 5);
        checkOutput("t4_clr_cnt1", OUT_CNT, 1);

        // load 1..4 and flush
        for (int k = 0; k < NUM_CH; k++) applyStimulus(1, k, k + 1, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        checkOutput("t5_busy_start", BUSY, 1);
        checkOutput("t5_in_ready_low", IN_READY, 0);
        for (int k = 0; k < NUM_CH; k++) begin
            @(negedge CLK);
            checkOutput("t5_flush_flag", OUT_FLUSH, 1);
            checkOutput("t5_flush_ch", OUT_CH, k);
            checkOutput("t5_flush_sum", OUT_SUM, k + 1);
            checkOutput("t5_busy", BUSY, (k < NUM_CH - 1) ? 1 : 0);
        end
        applyStimulus(1, 3, 1, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        checkOutput("t5_post_sum1", OUT_SUM, 1);
        checkOutput("t5_post_cnt1", OUT_CNT, 1);

        // reset in the middle of a flush
        for (int k = 0; k < 3; k++) applyStimulus(1, k, 7 + k, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(posedge CLK);
        @(posedge CLK);
        #1 RST_X = 1'b0;
        #1;
        checkOutput("t6_rst_valid", OUT_VALID, 0);
        checkOutput("t6_rst_busy", BUSY, 0);
        @(negedge CLK);
        #2 RST_X = 1'b1;
        applyStimulus(1, 3, 0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);
        checkOutput("t6_post_valid", OUT_VALID, 1);
        checkOutput("t6_post_sum0", OUT_SUM, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(0, 15)) : $urandom;
            rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, NUM_CH - 1), ra, rb,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 39) == 0,
                          $urandom_range(0, 9) < 7);
        end
        repeat (8) applyStimulus(0, 0, 0, 0, 0, 0, 1);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
